// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 power-up and register-configuration sequencer.
package ov5640_cfg_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    RST_WAIT,
    SETTLE,
    FETCH,
    ISSUE,
    RETRY_GAP,
    DELAY,
    NEXT,
    DONE,
    ERROR
  } cfg_state_e;

  localparam int unsigned ENTRY_W       = 24;
  localparam logic [15:0] DELAY_ADDR    = 16'hFFFF;
  localparam int unsigned RETRY_GAP_CYC = 16;

endpackage

// File: rtl/ov5640_cfg_rom.sv
// Constant OV5640 RGB565 init table, {addr[15:0], data[7:0]} per entry, one-cycle read latency.
module ov5640_cfg_rom
  import ov5640_cfg_pkg::*;
#(
  parameter int unsigned IdxW = 8
) (
  input  logic               clk_i,
  input  logic [IdxW-1:0]    addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [31:0]        idx;
  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] data_q;

  assign idx = 32'(addr_i);

  // Slots past the end of the list are zero-length delays, so they pass straight through.
  always_comb begin
    entry_d = {DELAY_ADDR, 8'h00};
    case (idx)
      0:  entry_d = 24'h300882;
      1:  entry_d = 24'hFFFF03;
      2:  entry_d = 24'h300842;
      3:  entry_d = 24'h310303;
      4:  entry_d = 24'h3017FF;
      5:  entry_d = 24'h3018FF;
      6:  entry_d = 24'h30341A;
      7:  entry_d = 24'h303713;
      8:  entry_d = 24'h310801;
      9:  entry_d = 24'h363036;
      10: entry_d = 24'h36310E;
      11: entry_d = 24'h3632E2;
      12: entry_d = 24'h363312;
      13: entry_d = 24'h3621E0;
      14: entry_d = 24'h3704A0;
      15: entry_d = 24'h37035A;
      16: entry_d = 24'h371578;
      17: entry_d = 24'h371701;
      18: entry_d = 24'h370B60;
      19: entry_d = 24'h37051A;
      20: entry_d = 24'h390502;
      21: entry_d = 24'h390610;
      22: entry_d = 24'h39010A;
      23: entry_d = 24'h373112;
      24: entry_d = 24'h360008;
      25: entry_d = 24'h360133;
      26: entry_d = 24'h430061;
      27: entry_d = 24'h501F01;
      28: entry_d = 24'h382041;
      29: entry_d = 24'h382107;
      30: entry_d = 24'h380802;
      31: entry_d = 24'h380980;
      32: entry_d = 24'h380A01;
      33: entry_d = 24'h380BE0;
      34: entry_d = 24'h303521;
      35: entry_d = 24'h300802;
      default: entry_d = {DELAY_ADDR, 8'h00};
    endcase
  end

  always_ff @(posedge clk_i) begin
    data_q <= entry_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 sequencer: PWDN/RESETB power-up timing, then walks the init table issuing SCCB writes.
module ov5640_cfg_ctrl
  import ov5640_cfg_pkg::*;
#(
  parameter int unsigned REG_NUM    = 256,
  parameter int unsigned PWDN_CYC   = 250000,
  parameter int unsigned RST_CYC    = 50000,
  parameter int unsigned SETTLE_CYC = 1000000,
  parameter int unsigned DELAY_CYC  = 250000,
  parameter int unsigned RETRY_MAX  = 3
) (
  input  logic                       s_clk,
  input  logic                       s_rst,
  input  logic                       cfg_start,
  output logic                       sccb_req,
  output logic [15:0]                sccb_addr,
  output logic [7:0]                 sccb_wdata,
  input  logic                       sccb_ack,
  input  logic                       sccb_nack,
  output logic                       cam_pwdn,
  output logic                       cam_rst_n,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic [$clog2(REG_NUM)-1:0] cfg_idx
);

  localparam int unsigned IDX_W   = $clog2(REG_NUM);
  localparam int unsigned DLY_MAX = 255 * DELAY_CYC;
  localparam int unsigned MAX_A   = (PWDN_CYC > RST_CYC) ? PWDN_CYC : RST_CYC;
  localparam int unsigned MAX_B   = (SETTLE_CYC > DLY_MAX) ? SETTLE_CYC : DLY_MAX;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MAX = (MAX_C > RETRY_GAP_CYC) ? MAX_C : RETRY_GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 2);

  cfg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               req_q, req_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               pwdn_q, pwdn_d;
  logic               rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ENTRY_W-1:0] rom_data;
  logic [CNT_W-1:0]   delay_tot;

  ov5640_cfg_rom #(
    .IdxW(IDX_W)
  ) u_rom (
    .clk_i (s_clk),
    .addr_i(idx_q),
    .data_o(rom_data)
  );

  // A delay entry keeps its unit count in the wdata register while req stays low.
  assign delay_tot = CNT_W'(32'(wdata_q) * DELAY_CYC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    idx_d   = idx_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pwdn_d  = pwdn_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CNT_W'(PWDN_CYC - 1)) begin
          state_d = RST_WAIT;
          pwdn_d  = 1'b0;
        end
      end
      RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = SETTLE;
          rst_n_d = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = FETCH;
      end
      FETCH: begin
        // Second FETCH cycle: the ROM output now reflects idx_q.
        if (cnt_q == CNT_W'(1)) begin
          addr_d  = rom_data[23:8];
          wdata_d = rom_data[7:0];
          if (rom_data[23:8] == DELAY_ADDR) begin
            state_d = DELAY;
          end else begin
            state_d = ISSUE;
            req_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (sccb_ack) begin
          req_d = 1'b0;
          if (!sccb_nack) begin
            retry_d = '0;
            state_d = NEXT;
          end else if (retry_q < RETRY_W'(RETRY_MAX)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = RETRY_GAP;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      RETRY_GAP: begin
        if (cnt_q == CNT_W'(RETRY_GAP_CYC - 1)) begin
          state_d = ISSUE;
          req_d   = 1'b1;
        end
      end
      DELAY: begin
        if (wdata_q == 8'd0 || cnt_q == delay_tot - CNT_W'(1)) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == IDX_W'(REG_NUM - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        if (cfg_start) begin
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      ERROR: begin
        if (cfg_start) begin
          err_d   = 1'b0;
          retry_d = '0;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pwdn_q  <= 1'b1;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pwdn_q  <= pwdn_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sccb_req   = req_q;
  assign sccb_addr  = addr_q;
  assign sccb_wdata = wdata_q;
  assign cam_pwdn   = pwdn_q;
  assign cam_rst_n  = rst_n_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign cfg_idx    = idx_q;

endmodule

// File: doc/ov5640_cfg_ctrl.md
Name: ov5640_cfg_ctrl

Overview:
Power-up and register-configuration sequencer for the OV5640 camera.
- Drives the sensor PWDN and RESETB pins through the datasheet timing.
- Walks a constant register table, issuing one write per entry to an external SCCB master over a req/ack handshake.
- Raises cfg_done when the table completes; cfg_done gates the pixel-capture path downstream.
- Supports re-running the table without repeating power-up, retries NACKed writes, and handles inline delay entries.

Parameters:
- REG_NUM, 256: number of table entries (index width = clog2(REG_NUM)).
- PWDN_CYC, 250000: s_clk cycles PWDN is held high after reset (5 ms at 50 MHz).
- RST_CYC, 50000: s_clk cycles RESETB is held low after PWDN falls (1 ms).
- SETTLE_CYC, 1000000: s_clk cycles after RESETB rises before the first SCCB access (20 ms).
- DELAY_CYC, 250000: s_clk cycles per unit of a delay entry.
- RETRY_MAX, 3: NACK retries per entry before error.

Ports:
- s_clk  in  1  system clock
- s_rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle pulse; re-runs the table from index 0 (honoured only in DONE or ERROR)
- sccb_req  out  1  write request to SCCB master
- sccb_addr  out  16  register address
- sccb_wdata  out  8  register data
- sccb_ack  in  1  one-cycle pulse, transaction finished
- sccb_nack  in  1  valid with sccb_ack; 1 = slave NACK
- cam_pwdn  out  1  sensor power-down pin
- cam_rst_n  out  1  sensor RESETB pin
- cfg_done  out  1  table completed successfully
- cfg_err  out  1  retry limit exhausted
- cfg_idx  out  clog2(REG_NUM)  current table index

Behaviour:
- Reset values: cam_pwdn=1, cam_rst_n=0, sccb_req=0, sccb_addr=0, sccb_wdata=0, cfg_done=0, cfg_err=0, cfg_idx=0, retry=0, state=PWR_WAIT, cycle counter=0.
- s_rst asserted in any state returns to these values on the next edge, including mid-transaction. The SCCB master is expected to abort on the dropped req.
- PWR_WAIT: cam_pwdn=1 for PWDN_CYC cycles, then state=RST_WAIT with cam_pwdn=0.
- RST_WAIT: cam_rst_n=0 for RST_CYC cycles, then cam_rst_n=1 and state=SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then state=FETCH.
- FETCH: present cfg_idx to the ROM. The ROM has 1-cycle read latency, so FETCH lasts exactly 2 cycles and the entry is registered at the end.
  - Entry format is 24 bits, {addr[15:0], data[7:0]}.
  - addr==16'hFFFF marks a delay entry: go to DELAY.
  - Any other addr: go to ISSUE.
- ISSUE: sccb_req=1, with sccb_addr and sccb_wdata stable until sccb_ack. req drops the cycle after ack is sampled.
  - ack with nack=0: clear retry, then go to NEXT.
  - ack with nack=1 and retry<RETRY_MAX: retry+1, go to RETRY_GAP (16 idle cycles, req=0), then back to ISSUE with the same entry.
  - ack with nack=1 and retry==RETRY_MAX: go to ERROR.
- DELAY: wait data*DELAY_CYC cycles (data=0 means zero wait, 1 cycle pass-through), then go to NEXT.
- NEXT: if cfg_idx==REG_NUM-1, go to DONE. Otherwise cfg_idx+1 and go to FETCH. cfg_idx never wraps.
- DONE: cfg_done=1 (level). A cfg_start pulse clears cfg_done, sets cfg_idx=0, and goes to FETCH; power-up is not repeated.
- ERROR: cfg_err=1, sccb_req=0, cfg_idx holds the failing entry. A cfg_start pulse clears cfg_err and retry, sets cfg_idx=0, and goes to FETCH.
- cfg_start is ignored in all states other than DONE and ERROR.
- An sccb_ack arriving outside ISSUE is ignored.
- A single shared cycle counter is used, wide enough for max(PWDN_CYC, SETTLE_CYC, 255*DELAY_CYC). It clears on every state entry.

Decomposition:
- Package ov5640_cfg_pkg:
  - State enum: PWR_WAIT, RST_WAIT, SETTLE, FETCH, ISSUE, RETRY_GAP, DELAY, NEXT, DONE, ERROR.
  - DELAY_ADDR=16'hFFFF.
  - RETRY_GAP_CYC=16.
  - Entry width 24.
- Sub-module ov5640_cfg_rom: synchronous-read constant table (addr in, 24-bit entry out, 1-cycle latency), holding the OV5640 RGB565 init list. The table starts with a 0x3008=0x82 software reset followed by a delay entry.

Test Plan:
- Reset release with PWDN_CYC=10, RST_CYC=5, SETTLE_CYC=20 -> cam_pwdn falls at cycle 10, cam_rst_n rises at cycle 15, first sccb_req at cycle 35+2.
- 4-entry table, SCCB model acks after 7 cycles with nack=0 -> 4 requests, addr/data match ROM in order, req held until ack and low 1 cycle after, cfg_done=1 with cfg_idx=3.
- Entry 1 NACKed twice, RETRY_MAX=3 -> 3 requests with identical addr/data, 16-cycle gaps, then continues; cfg_done=1, cfg_err=0.
- Entry 2 NACKed 4 times -> cfg_err=1, cfg_idx=2, req=0. A cfg_start pulse -> cfg_err clears and the table restarts at index 0 without PWDN/RESETB toggling.
- Delay entry {FFFF,03} with DELAY_CYC=4 -> no request for 12 cycles, next entry issued afterwards.
- s_rst asserted mid-ISSUE -> next cycle sccb_req=0, cam_pwdn=1, cam_rst_n=0, cfg_done=0; full power-up sequence repeats.
